// File: rtl/sram_buffer_ctrl.sv
// Request/ready controller that sequences setup/pulse/hold timing on an async SRAM.
// Optional address auto-increment counter is enabled with `define SRAM_AUTOINC_EN.
module sram_buffer_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int WR_CYC = 1,
  parameter int RD_CYC = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iREQ,
  input  logic              iWR,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic              iADDR_LD,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oREADY,
  output logic [DATA_W-1:0] oDATA,
  output logic              oVALID,
  output logic              oDONE,
  inout  wire  [DATA_W-1:0] Buffer_DQ,
  output logic [ADDR_W-1:0] Buffer_ADDR,
  output logic              Buffer_WE_N,
  output logic              Buffer_OE_N
);

  localparam int MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_SETUP = 3'd1;
  localparam logic [2:0] WR_PULSE = 3'd2;
  localparam logic [2:0] WR_HOLD  = 3'd3;
  localparam logic [2:0] RD_SETUP = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_dqOe;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] w_opAddr;
  logic              w_accept;

  assign oREADY    = (r_state == IDLE);
  assign w_accept  = iREQ & oREADY;
  assign Buffer_DQ = r_dqOe ? r_wdata : {DATA_W{1'bz}};

`ifdef SRAM_AUTOINC_EN
  logic [ADDR_W-1:0] r_addrCnt;

  assign w_opAddr = iADDR_LD ? iADDR : r_addrCnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_addrCnt <= '0;
    end else if (w_accept) begin
      r_addrCnt <= w_opAddr + ADDR_W'(1);
    end
  end
`else
  // Both arms are iADDR: the load strobe has no meaning without the counter.
  assign w_opAddr = iADDR_LD ? iADDR : iADDR;
`endif

  // Drive enable is only ever set on write entry and cleared on return to IDLE,
  // so OE_N (which only falls from RD_SETUP) can never overlap it.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dqOe      <= 1'b0;
      r_wdata     <= '0;
      oDATA       <= '0;
      oVALID      <= 1'b0;
      oDONE       <= 1'b0;
      Buffer_ADDR <= '0;
      Buffer_WE_N <= 1'b1;
      Buffer_OE_N <= 1'b1;
    end else begin
      oVALID <= 1'b0;
      oDONE  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iREQ) begin
            Buffer_ADDR <= w_opAddr;
            r_wdata     <= iDATA;
            if (iWR) begin
              r_state <= WR_SETUP;
              r_dqOe  <= 1'b1;
            end else begin
              r_state <= RD_SETUP;
            end
          end
        end
        WR_SETUP: begin
          r_state     <= WR_PULSE;
          Buffer_WE_N <= 1'b0;
          r_cnt       <= WR_LOAD;
        end
        WR_PULSE: begin
          if (r_cnt == '0) begin
            r_state     <= WR_HOLD;
            Buffer_WE_N <= 1'b1;
            oDONE       <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        WR_HOLD: begin
          r_state <= IDLE;
          r_dqOe  <= 1'b0;
        end
        RD_SETUP: begin
          r_state     <= RD_WAIT;
          Buffer_OE_N <= 1'b0;
          r_cnt       <= RD_LOAD;
        end
        RD_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= IDLE;
            Buffer_OE_N <= 1'b1;
            oDATA       <= Buffer_DQ;
            oVALID      <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_dqOe      <= 1'b0;
          Buffer_WE_N <= 1'b1;
          Buffer_OE_N <= 1'b1;
        end
      endcase
    end
  end

endmodule
